// File: rtl/shifter_seq_n_if.sv
// Handshake and data bundle between a producer and the shifter_seq_n sequential shifter.
`timescale 1ns/1ps
interface shifter_seq_n_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned AW = $clog2(WIDTH);

   logic             start;
   logic [2:0]       op;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] d;
   logic             ser_in;
   logic [WIDTH-1:0] q;
   logic             ser_out;
   logic             ready;
   logic             done;

   modport master (
      output start, op, amt, d, ser_in,
      input  q, ser_out, ready, done
   );

   modport slave (
      input  start, op, amt, d, ser_in,
      output q, ser_out, ready, done
   );
endinterface

// File: rtl/shifter_seq_n.sv
// Multi-cycle shift/rotate register: loads a word on start, then applies one 1-bit step of the
// requested mode per clock until the count is exhausted, then pulses done for one cycle.
`timescale 1ns/1ps
module shifter_seq_n #(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   shifter_seq_n_if.slave bus
);
   localparam int unsigned AW = $clog2(WIDTH);

   localparam logic [2:0] OpLoad = 3'b000;
   localparam logic [2:0] OpLsl  = 3'b001;
   localparam logic [2:0] OpLsr  = 3'b010;
   localparam logic [2:0] OpAsr  = 3'b011;
   localparam logic [2:0] OpRol  = 3'b100;
   localparam logic [2:0] OpRor  = 3'b101;
   localparam logic [2:0] OpSls  = 3'b110;
   localparam logic [2:0] OpSrs  = 3'b111;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] q_q;
   logic             ser_out_q;
   logic [AW-1:0]    cnt_q;
   logic [2:0]       op_q;
   logic             ready_q;
   logic             done_q;

   logic [WIDTH-1:0] step_q;
   logic             step_out;

   // One 1-bit step of the latched mode; step_out is the bit leaving q.
   always_comb begin
      step_q   = q_q;
      step_out = ser_out_q;
      case (op_q)
         OpLsl: begin
            step_q   = {q_q[WIDTH-2:0], 1'b0};
            step_out = q_q[WIDTH-1];
         end
         OpLsr: begin
            step_q   = {1'b0, q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         OpAsr: begin
            step_q   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         OpRol: begin
            step_q   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            step_out = q_q[WIDTH-1];
         end
         OpRor: begin
            step_q   = {q_q[0], q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         OpSls: begin
            step_q   = {q_q[WIDTH-2:0], bus.ser_in};
            step_out = q_q[WIDTH-1];
         end
         OpSrs: begin
            step_q   = {bus.ser_in, q_q[WIDTH-1:1]};
            step_out = q_q[0];
         end
         OpLoad: begin
            step_q   = q_q;
            step_out = ser_out_q;
         end
         default: begin
            step_q   = q_q;
            step_out = ser_out_q;
         end
      endcase
   end

   // ready/done are registered alongside the state so they mirror it without decode glitches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         q_q       <= '0;
         ser_out_q <= 1'b0;
         cnt_q     <= '0;
         op_q      <= OpLoad;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            StShift: begin
               q_q       <= step_q;
               ser_out_q <= step_out;
               cnt_q     <= cnt_q - AW'(1);
               if (cnt_q == AW'(1)) begin
                  state_q <= StDone;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               if (bus.start) begin
                  q_q       <= bus.d;
                  op_q      <= bus.op;
                  cnt_q     <= bus.amt;
                  ser_out_q <= 1'b0;
                  if (bus.op == OpLoad || bus.amt == '0) begin
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StShift;
                     ready_q <= 1'b0;
                     done_q  <= 1'b0;
                  end
               end else begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.q       = q_q;
   assign bus.ser_out = ser_out_q;
   assign bus.ready   = ready_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_shifter_seq_n.sv
// Scoreboard bench for shifter_seq_n: expected q/ser_out pushed at start, popped on done.
`timescale 1ns/1ps
module tb_shifter_seq_n;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned AW    = $clog2(WIDTH);

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   shifter_seq_n_if #(.WIDTH(WIDTH)) bus ();

   shifter_seq_n #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [WIDTH-1:0] q;
      logic             so;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Closed-form reference for a whole operation with ser_in held constant.
   function automatic exp_t model(input logic [2:0] op, input int amt,
                                  input logic [WIDTH-1:0] d, input logic s);
      exp_t r;
      logic [WIDTH-1:0] fill_l;
      logic [WIDTH-1:0] fill_r;
      r.q  = d;
      r.so = 1'b0;
      if (op == 3'b000 || amt == 0) return r;
      fill_l = '0;
      fill_r = '0;
      if (s) begin
         fill_l = ~({WIDTH{1'b1}} << amt);
         fill_r = ~({WIDTH{1'b1}} >> amt);
      end
      case (op)
         3'b001: r.q = d << amt;
         3'b010: r.q = d >> amt;
         3'b011: r.q = $signed(d) >>> amt;
         3'b100: r.q = (d << amt) | (d >> (WIDTH - amt));
         3'b101: r.q = (d >> amt) | (d << (WIDTH - amt));
         3'b110: r.q = (d << amt) | fill_l;
         default: r.q = (d >> amt) | fill_r;
      endcase
      if (op == 3'b001 || op == 3'b100 || op == 3'b110) r.so = d[WIDTH-amt];
      else r.so = d[amt-1];
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset_n && bus.done) begin
         if (sb.size() == 0) begin
            check_eq("sb_empty_on_done", sb.size(), 1);
         end else begin
            mon_e = sb.pop_front();
            check_eq("q", bus.q, mon_e.q);
            check_eq("ser_out", bus.ser_out, mon_e.so);
         end
      end
   end

   task automatic start_op(input logic [2:0] op, input int amt, input logic [WIDTH-1:0] d,
                           input logic s, input bit push);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.amt    = AW'(amt);
      bus.d      = d;
      bus.ser_in = s;
      if (push) sb.push_back(model(op, amt, d, s));
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready) return;
      end
      check_eq("ready_timeout", {31'b0, bus.ready}, 1);
   endtask

   // Counts rising edges until done is seen; ready must stay low meanwhile.
   task automatic wait_done(inout int edges);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) return;
         check_eq("ready_in_shift", {31'b0, bus.ready}, 0);
         @(posedge clk);
         edges++;
      end
      check_eq("done_timeout", {31'b0, bus.done}, 1);
   endtask

   task automatic run_op(input logic [2:0] op, input int amt, input logic [WIDTH-1:0] d,
                         input logic s, output int edges);
      wait_ready();
      start_op(op, amt, d, s, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      edges = 1;
      wait_done(edges);
   endtask

   initial begin
      int e;
      logic [2:0] r_op;
      int r_amt;

      reset_n    = 1'b0;
      bus.start  = 1'b1;
      bus.op     = 3'b001;
      bus.amt    = AW'(3);
      bus.d      = 8'h55;
      bus.ser_in = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_q", bus.q, 0);
      check_eq("rst_ready", {31'b0, bus.ready}, 1);
      check_eq("rst_done", {31'b0, bus.done}, 0);
      bus.start = 1'b0;
      reset_n   = 1'b1;

      run_op(3'b001, 3, 8'b01010101, 1'b0, e);
      check_eq("lsl_latency", e, 4);
      run_op(3'b011, 2, 8'b11101011, 1'b0, e);
      check_eq("asr_latency", e, 3);
      run_op(3'b101, 1, 8'b01111111, 1'b0, e);
      check_eq("ror_latency", e, 2);
      run_op(3'b000, 5, 8'hA5, 1'b0, e);
      check_eq("load_latency", e, 1);
      run_op(3'b001, 0, 8'hA5, 1'b0, e);
      check_eq("amt0_latency", e, 1);
      run_op(3'b110, 4, 8'h00, 1'b1, e);
      check_eq("sls_latency", e, 5);

      // start pulse during SHIFT with different data must be ignored
      wait_ready();
      start_op(3'b010, 5, 8'hC3, 1'b0, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1 start_op(3'b100, 1, 8'h0F, 1'b1, 1'b0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      e = 3;
      wait_done(e);
      check_eq("ignore_latency", e, 6);

      // back-to-back: new start accepted in the DONE cycle
      wait_ready();
      start_op(3'b111, 3, 8'h81, 1'b1, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      e = 1;
      wait_done(e);
      start_op(3'b100, 2, 8'h96, 1'b0, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      check_eq("b2b_no_idle", {31'b0, bus.ready}, 0);
      e = 1;
      wait_done(e);
      check_eq("b2b_latency", e, 3);

      // start held high re-accepts every ready cycle
      wait_ready();
      start_op(3'b000, 0, 8'h3C, 1'b0, 1'b1);
      @(negedge clk);
      check_eq("held_done1", {31'b0, bus.done}, 1);
      start_op(3'b000, 0, 8'h5A, 1'b0, 1'b1);
      @(negedge clk);
      check_eq("held_done2", {31'b0, bus.done}, 1);
      bus.start = 1'b0;
      @(negedge clk);
      check_eq("held_release", {31'b0, bus.done}, 0);

      // asynchronous reset mid-shift discards the operation
      wait_ready();
      start_op(3'b001, 5, 8'hFF, 1'b0, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check_eq("midrst_q", bus.q, 0);
      check_eq("midrst_ready", {31'b0, bus.ready}, 1);
      check_eq("midrst_done", {31'b0, bus.done}, 0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      run_op(3'b100, 3, 8'hB1, 1'b0, e);
      check_eq("post_rst_latency", e, 4);

      for (int i = 0; i < 24; i++) begin
         r_op  = 3'($urandom_range(0, 7));
         r_amt = int'($urandom_range(0, WIDTH - 1));
         run_op(r_op, r_amt, 8'($urandom), 1'($urandom), e);
         check_eq("rand_latency", e, (r_op == 3'b000 || r_amt == 0) ? 1 : r_amt + 1);
      end

      @(negedge clk);
      check_eq("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
